// File: rtl/cpu_bus_serializer.sv
// cpu_bus_serializer
//   Bridges the CPU core's parallel memory port to a narrow off-chip bus.
//   A transaction goes out as ADDR_W/PIN_W address beats (LSB first), one
//   command beat {0.., valid, we}, a WAIT phase for the device ack, and then
//   DATA_W/PIN_W data beats (LSB first). Write data is driven out. Read data
//   is sampled back in and presented on cpu_rdata together with cpu_ready.
//   WAIT gives up after TIMEOUT cycles and reports cpu_err (TIMEOUT=0 waits
//   forever).
//
// Ports
//   clk        in   single clock, posedge
//   rst_n      in   synchronous active-low reset
//   cpu_req    in   transaction request, sampled in IDLE only
//   cpu_we     in   1 = write, 0 = read
//   cpu_addr   in   [ADDR_W] transaction address
//   cpu_wdata  in   [DATA_W] write data
//   cpu_ready  out  one-cycle completion pulse
//   cpu_rdata  out  [DATA_W] assembled read data, held until the next read
//   cpu_err    out  valid with cpu_ready, 1 = timeout
//   bus_addr   out  [PIN_W] address / command beat pins
//   bus_dout   out  [PIN_W] write-data pins
//   bus_oe     out  [PIN_W] all-ones while driving write data
//   bus_din    in   [PIN_W] read-data pins
//   bus_strb   out  high on every address, command or data beat
//   bus_ack    in   device ready for the data phase
module cpu_bus_serializer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PIN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [PIN_W-1:0]  bus_addr,
  output logic [PIN_W-1:0]  bus_dout,
  output logic [PIN_W-1:0]  bus_oe,
  input  logic [PIN_W-1:0]  bus_din,
  output logic              bus_strb,
  input  logic              bus_ack
);

  localparam int AB   = ADDR_W / PIN_W;
  localparam int DB   = DATA_W / PIN_W;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int BW   = $clog2(MAXB) + 1;
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BW-1:0]    AB_LAST  = BW'(AB - 1);
  localparam logic [BW-1:0]    DB_LAST  = BW'(DB - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PIN_W-1:0] CMD_VLD  = PIN_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CMD, S_WAIT, S_DATA, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [BW-1:0]     beat, beat_d;
  logic [TW-1:0]     tmo_cnt, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_sh, addr_sh_d;
  logic [DATA_W-1:0] wdata_sh, wdata_sh_d;
  logic [DATA_W-1:0] rdata_sh, rdata_sh_d;
  logic [PIN_W-1:0]  bus_addr_d, bus_dout_d, bus_oe_d;
  logic              bus_strb_d, ready_d, err_d;
  logic [DATA_W-1:0] rdata_d;

  // Outputs are computed from the next state and then registered, so each
  // beat appears on the pins in the same cycle its state is occupied.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state;
    beat_d     = beat;
    tmo_d      = tmo_cnt;
    we_d       = we_q;
    addr_sh_d  = addr_sh;
    wdata_sh_d = wdata_sh;
    rdata_sh_d = rdata_sh;
    bus_addr_d = '0;
    bus_dout_d = '0;
    bus_oe_d   = '0;
    bus_strb_d = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = cpu_rdata;

    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          we_d       = cpu_we;
          wdata_sh_d = cpu_wdata;
          // Beat 0 goes out straight from the port. The shifter keeps the rest.
          addr_sh_d  = cpu_addr >> PIN_W;
          bus_addr_d = cpu_addr[PIN_W-1:0];
          bus_strb_d = 1'b1;
          beat_d     = '0;
          state_d    = S_ADDR;
        end
      end

      S_ADDR: begin
        bus_strb_d = 1'b1;
        if (beat == AB_LAST) begin
          bus_addr_d = CMD_VLD | PIN_W'(we_q);
          state_d    = S_CMD;
        end else begin
          bus_addr_d = addr_sh[PIN_W-1:0];
          addr_sh_d  = addr_sh >> PIN_W;
          beat_d     = beat + BW'(1);
        end
      end

      S_CMD: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Ack takes priority over a timeout that expires in the same cycle.
        if (bus_ack) begin
          beat_d     = '0;
          bus_strb_d = 1'b1;
          if (we_q) begin
            bus_dout_d = wdata_sh[PIN_W-1:0];
            bus_oe_d   = '1;
            wdata_sh_d = wdata_sh >> PIN_W;
          end
          state_d = S_DATA;
        end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (tmo_cnt != '1) begin
          tmo_d = tmo_cnt + TW'(1);
        end
      end

      S_DATA: begin
        // Read beats enter at the top so that, after DB shifts, beat 0 sits in
        // the low bits.
        if (!we_q)
          rdata_sh_d = (rdata_sh >> PIN_W) | (DATA_W'(bus_din) << (DATA_W - PIN_W));
        if (beat == DB_LAST) begin
          ready_d = 1'b1;
          if (!we_q)
            rdata_d = rdata_sh_d;
          state_d = S_DONE;
        end else begin
          bus_strb_d = 1'b1;
          if (we_q) begin
            bus_dout_d = wdata_sh[PIN_W-1:0];
            bus_oe_d   = '1;
            wdata_sh_d = wdata_sh >> PIN_W;
          end
          beat_d = beat + BW'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat      <= '0;
      tmo_cnt   <= '0;
      we_q      <= 1'b0;
      addr_sh   <= '0;
      wdata_sh  <= '0;
      rdata_sh  <= '0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      bus_oe    <= '0;
      bus_strb  <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_d;
      beat      <= beat_d;
      tmo_cnt   <= tmo_d;
      we_q      <= we_d;
      addr_sh   <= addr_sh_d;
      wdata_sh  <= wdata_sh_d;
      rdata_sh  <= rdata_sh_d;
      bus_addr  <= bus_addr_d;
      bus_dout  <= bus_dout_d;
      bus_oe    <= bus_oe_d;
      bus_strb  <= bus_strb_d;
      cpu_ready <= ready_d;
      cpu_err   <= err_d;
      cpu_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// tb_cpu_bus_serializer
//   Exercises three instances: default widths, TIMEOUT=4, and 16/16/4 widths.
//   sel chooses which instance receives req/ack and which one is observed.
//   The expected per-cycle pin trace comes from the beat rules (address beats,
//   command, wait cycles, data beats, done) and is built into a queue. That
//   queue is then compared cycle by cycle against the observed outputs.
module tb_cpu_bus_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, ack;
  logic [31:0] addr, wdata;
  logic [7:0]  din;
  int          sel;

  always #5 clk = ~clk;

  logic req0, req1, req2, ack0, ack1, ack2;
  assign req0 = req && (sel == 0);
  assign req1 = req && (sel == 1);
  assign req2 = req && (sel == 2);
  assign ack0 = ack && (sel == 0);
  assign ack1 = ack && (sel == 1);
  assign ack2 = ack && (sel == 2);

  logic        r0, e0, s0, r1, e1, s1, r2, e2, s2;
  logic [31:0] rd0, rd1;
  logic [15:0] rd2;
  logic [7:0]  a0, d0, o0, a1, d1, o1;
  logic [3:0]  a2, d2, o2;

  cpu_bus_serializer u_def (
    .clk(clk), .rst_n(rst_n), .cpu_req(req0), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ready(r0), .cpu_rdata(rd0), .cpu_err(e0),
    .bus_addr(a0), .bus_dout(d0), .bus_oe(o0), .bus_din(din), .bus_strb(s0),
    .bus_ack(ack0));

  cpu_bus_serializer #(.TIMEOUT(4)) u_tmo (
    .clk(clk), .rst_n(rst_n), .cpu_req(req1), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ready(r1), .cpu_rdata(rd1), .cpu_err(e1),
    .bus_addr(a1), .bus_dout(d1), .bus_oe(o1), .bus_din(din), .bus_strb(s1),
    .bus_ack(ack1));

  cpu_bus_serializer #(.ADDR_W(16), .DATA_W(16), .PIN_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .cpu_req(req2), .cpu_we(we), .cpu_addr(addr[15:0]),
    .cpu_wdata(wdata[15:0]), .cpu_ready(r2), .cpu_rdata(rd2), .cpu_err(e2),
    .bus_addr(a2), .bus_dout(d2), .bus_oe(o2), .bus_din(din[3:0]), .bus_strb(s2),
    .bus_ack(ack2));

  // Observed vector: {ready, err, strb, oe[8], addr[8], dout[8]}
  logic [26:0] obs_vec;
  logic [31:0] obs_rd;
  always_comb begin
    obs_vec = '0;
    obs_rd  = '0;
    case (sel)
      0: begin obs_vec = {r0, e0, s0, o0, a0, d0}; obs_rd = rd0; end
      1: begin obs_vec = {r1, e1, s1, o1, a1, d1}; obs_rd = rd1; end
      default: begin
        obs_vec = {r2, e2, s2, 4'h0, o2, 4'h0, a2, 4'h0, d2};
        obs_rd  = {16'h0, rd2};
      end
    endcase
  end

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rd [3];

  function automatic logic [26:0] vec(bit r, bit e, bit s, logic [7:0] o,
                                      logic [7:0] a, logic [7:0] d);
    return {r, e, s, o, a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(posedge clk); #1;
      check(tag, 32'(obs_vec), 32'h0);
    end
  endtask

  // One transaction on the selected instance.
  //   wl        : ack stays low for wl WAIT cycles, then pulses high
  //   hold      : keep req high through DONE (back-to-back)
  //   abort_idx : cycle index at which reset is applied (-1 = none)
  //   exp_lat   : required req-to-ready latency (0 = not checked)
  task automatic run_txn(input string tag, input bit w_, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rv, input int wl,
                         input bit hold, input int abort_idx, input int exp_lat);
    int ab, db, pw, tmo, nwait, ds, lat;
    bit to;
    logic [31:0] mask, asm_rd;
    logic [26:0] q[$];
    ab = 4; db = 4; pw = 8; tmo = 255;
    if (sel == 1) tmo = 4;
    if (sel == 2) pw = 4;
    mask  = (32'd1 << pw) - 32'd1;
    to    = (tmo != 0) && (wl >= tmo);
    nwait = to ? tmo : wl + 1;
    ds    = ab + 1 + nwait;

    for (int i = 0; i < ab; i++)
      q.push_back(vec(0, 0, 1, 8'h0, 8'((a >> (i * pw)) & mask), 8'h0));
    q.push_back(vec(0, 0, 1, 8'h0, 8'(32'd2 + 32'(w_)), 8'h0));
    for (int i = 0; i < nwait; i++) q.push_back('0);
    if (!to)
      for (int j = 0; j < db; j++)
        q.push_back(vec(0, 0, 1, w_ ? 8'(mask) : 8'h0, 8'h0,
                        w_ ? 8'((wd >> (j * pw)) & mask) : 8'h0));
    q.push_back(vec(1, to, 0, 8'h0, 8'h0, 8'h0));
    q.push_back('0);

    asm_rd = '0;
    for (int j = 0; j < db; j++)
      asm_rd = asm_rd | (((rv >> (j * pw)) & mask) << (j * pw));

    req = 1'b1; we = w_; addr = a; wdata = wd; ack = 1'b0; din = 8'($urandom);
    @(posedge clk); #1;
    lat = -1;
    for (int idx = 0; idx < q.size(); idx++) begin
      check($sformatf("%s cyc%0d", tag, idx), 32'(obs_vec), 32'(q[idx]));
      if (obs_vec[26] && lat < 0) lat = idx + 2;
      if (idx == abort_idx) begin
        rst_n = 1'b0; req = 1'b0; ack = 1'b0;
        @(posedge clk); #1;
        check({tag, " rst outs"}, 32'(obs_vec), 32'h0);
        check({tag, " rst rdata"}, obs_rd, 32'h0);
        rst_n = 1'b1;
        exp_rd[sel] = '0;
        idle(3, {tag, " no ready after rst"});
        return;
      end
      ack = !to && (idx == ab + 1 + wl);
      din = (idx >= ds && idx < ds + db) ? 8'((rv >> ((idx - ds) * pw)) & mask)
                                         : 8'($urandom);
      if (idx == q.size() - 2 && !hold) req = 1'b0;
      if (idx < q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    ack = 1'b0;
    if (!to && !w_) exp_rd[sel] = asm_rd;
    check({tag, " rdata"}, obs_rd, exp_rd[sel]);
    if (exp_lat > 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; din = '0; sel = 0;
    for (int s = 0; s < 3; s++) exp_rd[s] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check($sformatf("reset outs dut%0d", s), 32'(obs_vec), 32'h0);
      check($sformatf("reset rdata dut%0d", s), obs_rd, 32'h0);
    end
    rst_n = 1'b1;

    // Default instance: directed cases
    sel = 0;
    idle(2, "idle0");
    run_txn("wr_dflt", 1'b1, 32'h1234_5678, 32'hA1B2_C3D4, 32'h0, 0, 1'b0, -1, 12);
    idle(1, "gap");
    run_txn("rd_dflt", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, -1, 12);
    idle(1, "gap");
    run_txn("wr_wait5", 1'b1, 32'hCAFE_0001, 32'h5566_7788, 32'h0, 5, 1'b0, -1, 17);
    idle(1, "gap");
    run_txn("wr_rst", 1'b1, 32'h0BAD_F00D, 32'h1122_3344, 32'h0, 0, 1'b0, 8, 0);
    run_txn("rd_after_rst", 1'b0, 32'h0000_0020, 32'h0, 32'h0102_0304, 0, 1'b0, -1, 12);

    // Default instance: random
    for (int k = 0; k < 6; k++) begin
      run_txn($sformatf("rand0_%0d", k), 1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 6)), 1'b0, -1, 0);
      idle(int'($urandom_range(0, 2)), "rgap");
    end

    // TIMEOUT=4 instance
    sel = 1;
    idle(1, "idle1");
    run_txn("rd_pre_tmo", 1'b0, 32'h0000_0040, 32'h0, 32'h8765_4321, 0, 1'b0, -1, 12);
    run_txn("timeout", 1'b0, 32'h0000_0044, 32'h0, 32'hFFFF_FFFF, 1000, 1'b0, -1, 11);
    run_txn("ack_wins", 1'b1, 32'h0000_0048, 32'h9999_AAAA, 32'h0, 3, 1'b0, -1, 15);
    run_txn("tmo_edge", 1'b1, 32'h0000_004C, 32'hBBBB_CCCC, 32'h0, 4, 1'b0, -1, 11);
    for (int k = 0; k < 4; k++)
      run_txn($sformatf("rand1_%0d", k), 1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 6)), 1'b0, -1, 0);

    // 16/16/4 instance, including back-to-back with req held high
    sel = 2;
    idle(1, "idle2");
    run_txn("s_wr", 1'b1, 32'h0000_A5C3, 32'h0000_1E2F, 32'h0, 0, 1'b1, -1, 12);
    run_txn("s_b2b_rd", 1'b0, 32'h0000_7F01, 32'h0, 32'h0000_BEEF, 0, 1'b1, -1, 12);
    run_txn("s_b2b_wr", 1'b1, 32'h0000_0246, 32'h0000_9753, 32'h0, 2, 1'b0, -1, 14);
    for (int k = 0; k < 4; k++)
      run_txn($sformatf("rand2_%0d", k), 1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 4)), 1'b0, -1, 0);
    idle(2, "end idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
